// File: rtl/irq_encoder_pkg.sv
// Shared types and constants for the edge-triggered interrupt encoder.
package irq_encoder_pkg;
  localparam int NUM_LINES = 16;
  localparam int IDX_W     = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;
endpackage

// File: rtl/prio_enc16.sv
// Combinational highest-set-bit encoder over the request lines.
module prio_enc16
  import irq_encoder_pkg::*;
(
  input  logic [NUM_LINES-1:0] req,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  // Ascending scan: the last set bit visited is the highest index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_encoder.sv
// Edge-captured interrupt encoder: latches rising edges as pending requests and
// presents the highest-priority one over a valid/ready handshake.
module irq_encoder
  import irq_encoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] in,
  input  logic                 enable,
  output logic [IDX_W-1:0]     out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 ovf,
  output logic [CNT_W-1:0]     lost,
  input  logic                 clr_ovf
);

  localparam logic [CNT_W-1:0] LOST_MAX = '1;

  logic [NUM_LINES-1:0] in_d_reg;
  logic [NUM_LINES-1:0] pending_reg, pending_next;
  logic [NUM_LINES-1:0] rise, cap, clr_mask;
  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     out_reg, out_next;
  logic                 ovf_reg, ovf_next;
  logic [CNT_W-1:0]     lost_reg, lost_next;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;
  logic                 accept;
  logic                 ov_hit;

  assign accept = (state_reg == PRESENT) && ready;

  // Set beats clear, so an edge on the line being accepted re-arms it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      assign rise[gi]         = in[gi] & ~in_d_reg[gi];
      assign cap[gi]          = enable & rise[gi];
      assign clr_mask[gi]     = accept && (out_reg == IDX_W'(gi));
      assign pending_next[gi] = cap[gi] | (pending_reg[gi] & ~clr_mask[gi]);
    end
  endgenerate

  // A line being accepted this cycle is not counted as an overflow.
  assign ov_hit = |(cap & pending_reg & ~clr_mask);

  prio_enc16 u_prio (
    .req (pending_reg),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (win_any) begin
          state_next = PRESENT;
          out_next   = win_idx;
        end
      end
      PRESENT: begin
        if (ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ovf_next  = ovf_reg;
    lost_next = lost_reg;
    if (clr_ovf) begin
      ovf_next  = ov_hit;
      lost_next = ov_hit ? CNT_W'(1) : '0;
    end else begin
      ovf_next = ovf_reg | ov_hit;
      if (ov_hit && (lost_reg != LOST_MAX)) lost_next = lost_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    in_d_reg <= in;
    if (rst) begin
      pending_reg <= '0;
      state_reg   <= IDLE;
      out_reg     <= '0;
      ovf_reg     <= 1'b0;
      lost_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      state_reg   <= state_next;
      out_reg     <= out_next;
      ovf_reg     <= ovf_next;
      lost_reg    <= lost_next;
    end
  end

  assign out   = out_reg;
  assign valid = (state_reg == PRESENT);
  assign ovf   = ovf_reg;
  assign lost  = lost_reg;

endmodule

// File: tb/tb_irq_encoder.sv
// Scoreboard bench for irq_encoder: directed stimulus queues expected indices,
// a negedge monitor pops them on every accepted handshake.
module tb_irq_encoder;

  localparam int CNT_W = 2;
  localparam logic [15:0] BASE = 16'h0002;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      in;
  logic             enable;
  logic [3:0]       out;
  logic             valid;
  logic             ready;
  logic             ovf;
  logic [CNT_W-1:0] lost;
  logic             clr_ovf;

  int vectors = 0;
  int miscompares = 0;
  int sb[$];

  irq_encoder #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .enable  (enable),
    .out     (out),
    .valid   (valid),
    .ready   (ready),
    .ovf     (ovf),
    .lost    (lost),
    .clr_ovf (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_accept: got out=%0d, expected no output", out);
      end else begin
        int e;
        e = sb.pop_front();
        chk("accept_out", int'(out), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vpat[7];
    int lpat[4];
    vpat = '{0, 1, 0, 1, 0, 1, 0};
    lpat = '{2, 3, 3, 3};
    rst = 1'b1; in = BASE; enable = 1'b1; ready = 1'b0; clr_ovf = 1'b0;
    step(2);
    chk("reset_valid", int'(valid), 0);
    chk("reset_out", int'(out), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_lost", int'(lost), 0);
    rst = 1'b0;
    step(3);
    chk("held_high_no_req", int'(valid), 0);

    // single request on line 5
    ready = 1'b1;
    sb.push_back(5);
    in = BASE | 16'h0020;
    step(1);
    chk("single_latency_low", int'(valid), 0);
    step(1);
    chk("single_valid", int'(valid), 1);
    chk("single_out", int'(out), 5);
    step(1);
    chk("single_cleared", int'(valid), 0);
    in = BASE;
    step(3);
    chk("single_q_empty", sb.size(), 0);

    // simultaneous 3, 9, 12
    sb.push_back(12); sb.push_back(9); sb.push_back(3);
    in = BASE | 16'h1208;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk($sformatf("multi_valid_c%0d", k + 1), int'(valid), vpat[k]);
    end
    in = BASE;
    step(3);
    chk("multi_q_empty", sb.size(), 0);

    // backpressure: line 2 presented, line 14 arrives
    ready = 1'b0;
    sb.push_back(2); sb.push_back(14);
    in = BASE | 16'h0004;
    step(2);
    in = BASE | 16'h4004;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk($sformatf("bp_hold_out_c%0d", k), int'(out), 2);
      chk($sformatf("bp_hold_valid_c%0d", k), int'(valid), 1);
    end
    ready = 1'b1;
    step(1);
    chk("bp_gap", int'(valid), 0);
    step(1);
    chk("bp_next_out", int'(out), 14);
    in = BASE;
    step(3);
    chk("bp_q_empty", sb.size(), 0);

    // overflow and saturation
    ready = 1'b0;
    sb.push_back(11); sb.push_back(10); sb.push_back(7);
    in = BASE | 16'h0C80;
    step(2);
    chk("ovf_present_out", int'(out), 11);
    chk("ovf_none_yet", int'(ovf), 0);
    in = BASE | 16'h0C00;
    step(1);
    in = BASE | 16'h0C80;
    step(1);
    chk("ovf_first_flag", int'(ovf), 1);
    chk("ovf_first_lost", int'(lost), 1);
    for (int k = 0; k < 4; k++) begin
      in = BASE | 16'h0C00;
      step(1);
      in = BASE | 16'h0C80;
      step(1);
      chk($sformatf("ovf_lost_iter%0d", k), int'(lost), lpat[k]);
    end
    chk("ovf_sat_flag", int'(ovf), 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_lost", int'(lost), 0);
    in = BASE | 16'h0080;
    step(1);
    in = BASE | 16'h0C80;
    step(1);
    chk("multi_line_lost", int'(lost), 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    in = BASE | 16'h0C00;
    step(1);
    in = BASE | 16'h0C80;
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("clr_coincide_ovf", int'(ovf), 1);
    chk("clr_coincide_lost", int'(lost), 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    ready = 1'b1;
    step(8);
    chk("ovf_q_empty", sb.size(), 0);
    in = BASE;
    step(2);

    // enable low drops edges
    enable = 1'b0;
    in = BASE | 16'h0010;
    step(4);
    chk("disabled_no_valid", int'(valid), 0);
    enable = 1'b1;
    step(2);
    chk("reenabled_no_valid", int'(valid), 0);
    in = BASE;
    step(1);

    // reset mid-handshake
    ready = 1'b0;
    in = BASE | 16'h2000;
    step(2);
    chk("pre_rst_valid", int'(valid), 1);
    chk("pre_rst_out", int'(out), 13);
    rst = 1'b1;
    step(1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_out", int'(out), 0);
    rst = 1'b0;
    step(3);
    chk("post_rst_no_pending", int'(valid), 0);
    ready = 1'b1;
    step(2);
    in = BASE;
    step(1);

    // edge on line 6 coinciding with its accept
    sb.push_back(6); sb.push_back(6);
    in = BASE | 16'h0040;
    step(1);
    in = BASE;
    step(1);
    chk("coin_valid", int'(valid), 1);
    chk("coin_out", int'(out), 6);
    in = BASE | 16'h0040;
    step(1);
    chk("coin_gap", int'(valid), 0);
    step(1);
    chk("coin_revalid", int'(valid), 1);
    chk("coin_reout", int'(out), 6);
    step(1);
    chk("coin_ovf", int'(ovf), 0);
    chk("coin_lost", int'(lost), 0);
    in = BASE;
    step(4);
    chk("final_q_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_encoder.md
IRQ_ENCODER -- requirements
Module: irq_encoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the lost-event counter.
REQ-002 Ports, clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in  input  16  request lines; a 0->1 transition raises a request.
- enable  input  1  1 = capture request edges; 0 = ignore new edges.
- out  output  4  binary index of the request being presented.
- valid  output  1  out holds a request.
- ready  input  1  consumer accepts out when valid&&ready at a rising clk.
- ovf  output  1  sticky flag: at least one edge arrived on an already-pending line.
- lost  output  CNT_W  saturating count of such edges.
- clr_ovf  input  1  clears ovf and lost.

Function
REQ-003 Edge detection: a register in_d shall hold the previous sample of in; edge[i] = in[i] & ~in_d[i]; in_d updates every cycle regardless of enable.
REQ-004 Capture: at a rising edge where enable=1 and edge[i]=1, pending[i] shall be set.
REQ-005 enable=0 shall drop edges without recording them, retain pending, and leave the handshake running.
REQ-006 Priority: the highest set index of pending wins (bit 15 highest, bit 0 lowest).
REQ-007 FSM states: IDLE and PRESENT.
REQ-008 IDLE -> PRESENT when pending!=0; out loads the winning index and valid=1 from the same edge.
REQ-009 PRESENT with ready=0: out and valid shall hold stable, even if a higher-priority bit becomes pending.
REQ-010 PRESENT with ready=1: pending[out] shall clear, valid=0, and the FSM returns to IDLE.
REQ-011 Timing: one accept per two cycles at most. The next valid is asserted no earlier than the edge after the accept.
REQ-012 Latency: edge sampled at clk edge k sets pending at k; valid is visible after edge k+1 when the FSM is in IDLE.
REQ-013 In IDLE, out shall hold its last value; consumers qualify out with valid only.
REQ-014 Overflow: enable=1, edge[i]=1 and pending[i]=1 at the same edge shall set ovf and increment lost, saturating at 2^CNT_W-1.
REQ-015 Multiple overflowing lines in one cycle shall increment lost by one only.
REQ-016 If the set and clear of pending[i] coincide (edge on the line being accepted):
- set wins and pending[i] stays 1;
- the event does not count as overflow.
REQ-017 If clr_ovf and an overflow event coincide: ovf=1 and lost=1.

Reset
REQ-018 rst=1 shall force: pending=0, state=IDLE, valid=0, out=0, ovf=0, lost=0.
REQ-019 During rst, in_d shall load in, so lines already high at reset release produce no request.
REQ-020 Reset asserted mid-handshake shall abandon the presented request with no acknowledge side effects.

Structure
REQ-021 Shared package shall hold the FSM state typedef (IDLE, PRESENT), the line-count constant 16, and the index-width constant 4.
REQ-022 The combinational 16-to-4 highest-set-bit encoder shall be a sub-module named prio_enc16, with an any-set output.
REQ-023 Target size 120-400 RTL lines; no other sub-modules.

Verification
REQ-024 Single request: in[5] 0->1, ready=1 -> valid high one cycle after pending sets, out=5; pending clears on accept.
REQ-025 Simultaneous requests: in[3], in[9] and in[12] rise together, ready=1 -> out sequence 12, 9, 3, each separated by one valid-low cycle.
REQ-026 Backpressure: in[2] pending, ready=0 for 5 cycles while in[14] rises -> out stays 2; after the accept, out=14.
REQ-027 Overflow: in[7] toggles 0->1->0->1 while unaccepted -> ovf=1, lost=1. With CNT_W=2 and 4 further overflows -> lost=3 (saturated). Asserting clr_ovf -> ovf=0, lost=0.
REQ-028 Enable and reset edges:
- in[4] rises with enable=0 -> no valid.
- in[1] held high through rst release -> no request.
- rst asserted while valid=1 -> valid=0 next edge, pending=0.
REQ-029 Coincidence: in[6] re-rises on the same edge its accept occurs -> valid reasserts with out=6; ovf stays 0.
